id_ex_issue: RTL
================

// Module: id_ex_issue
// PURPOSE
//  ID->EX issue register for the ALU stage. Latches one decoded instruction, presents operands and alu_op to
//  the ALU, and holds them stable for multi-cycle MUL/DIV until the ALU signals done. Merges the single-cycle
//  and multi-cycle results into one valid/ready stream towards MEM, buffering a completed MUL/DIV result if MEM stalls.
// PARAMETERS
//  MC_TIMEOUT  64  max MC_BUSY cycles before mc_timeout sets (debug/assert aid)
// PORTS
//  cpu_clk       in   1   clock; all state on rising edge
//  cpu_rstn      in   1   asynchronous, active-low reset
//  id_valid      in   1   ID presents an instruction
//  id_ready      out  1   issue register accepts this cycle (combinational)
//  id_pc         in   32  instruction PC
//  id_alu_op     in   8   ALU opcode (`ALU_* codes)
//  id_src1       in   32  operand A
//  id_src2       in   32  operand B
//  id_rd         in   5   destination register
//  id_rf_we      in   1   register write enable
//  flush         in   1   redirect from EX this cycle: discard the ID-side instruction
//  ex_alu_op     out  8   to ALU alu_op
//  ex_A          out  32  to ALU A
//  ex_B          out  32  to ALU B
//  alu_c         in   32  ALU result C
//  mc_done       in   1   ALU MUL/DIV done pulse (1 cycle)
//  mem_ready     in   1   MEM accepts ex_out_* this cycle
//  ex_out_valid  out  1   result valid to MEM
//  ex_out_res    out  32  result (alu_c, or held buffer in MC_HOLD)
//  ex_out_pc     out  32  PC of the retiring instruction
//  ex_out_rd     out  5   destination register
//  ex_out_rf_we  out  1   write enable
//  mc_timeout    out  1   sticky: an MC_BUSY run exceeded MC_TIMEOUT
// BEHAVIOUR
//  is_mc(op) = op in {MULW, MULHW, MULHWU, DIVW, DIVWU, MODW, MODWU}.
//  accept = id_valid & id_ready & !flush; on accept, load pc/op/src1/src2/rd/rf_we.
//  flush with id_valid: the instruction is consumed and dropped (no load); this EX instr still retires.
//  FSM states EMPTY, ISSUE, MC_BUSY, MC_HOLD. nxt = accept ? (is_mc(id_alu_op) ? MC_BUSY : ISSUE) : EMPTY.
//   EMPTY  : id_ready=1; ex_out_valid=0; -> nxt.
//   ISSUE  : ex_out_valid=1, res=alu_c; id_ready=mem_ready; mem_ready ? -> nxt : stay (regs held).
//   MC_BUSY: ex_out_valid=mc_done, res=alu_c; id_ready=mc_done&mem_ready; count++.
//            mc_done&mem_ready -> nxt; mc_done&!mem_ready -> MC_HOLD, buffer<=alu_c; else stay.
//   MC_HOLD: ex_out_valid=1, res=buffer; id_ready=mem_ready; mem_ready ? -> nxt : stay.
//  ex_alu_op = `ALU_NOP in EMPTY and MC_HOLD (stops the ALU re-starting the MUL/DIV after done drops), otherwise
//  the latched op. ex_A/ex_B = latched operands in every state; never change while MC_BUSY.
//  First ALU result available >=2 cycles after entry to MC_BUSY (ALU start register); single-cycle ops: result
//  in the cycle after accept. Back-to-back single-cycle issue at 1 instr/cycle when mem_ready=1.
//  mc_done outside MC_BUSY is ignored. Counter clears on MC_BUSY entry; reaching MC_TIMEOUT sets mc_timeout
//  (stays set until reset); the FSM keeps waiting.
//  Reset (async, any state): state=EMPTY, all latched fields/buffer/counter=0, ex_alu_op=`ALU_NOP,
//  ex_out_valid=0, mc_timeout=0; id_ready=1 after release. Reset mid MC_BUSY abandons the op.
// STRUCTURE
//  defines.vh: `ALU_NOP (8'h00, new), existing `ALU_* codes, `IS_MC_OP(op) macro shared with the ALU.
//  FSM state encodings local (localparam). No sub-module; single file.
// TESTING
//  1 ADD 5,7 then SUB 9,4 back-to-back, mem_ready=1 -> out 12 then 5 on consecutive cycles; id_ready stays 1.
//  2 MULW 3,-4; mc_done after 34 cycles -> id_ready=0 throughout; out 0xFFFFFFF4 on done cycle; ex_alu_op=NOP next.
//  3 DIVW -7,2, mem_ready=0 at mc_done -> MC_HOLD, res 0xFFFFFFFD held, ex_alu_op=NOP; mem_ready=1 -> exactly one transfer.
//  4 flush=1 with id_valid=1 in EMPTY -> no load; ex_out_valid=0 next cycle; following instr issues normally.
//  5 MULHWU with mc_done held 0 -> mc_timeout=1 after 64 MC_BUSY cycles, state still MC_BUSY.
//  6 cpu_rstn low mid MC_BUSY -> immediately EMPTY, all outputs 0, ex_alu_op=NOP; new ADD issues after release.

Source files
------------

// File: rtl/id_ex_issue_pkg.sv
// Shared ALU opcode map and multi-cycle op classification for the EX stage.
package id_ex_issue_pkg;

    localparam logic [7:0] ALU_NOP    = 8'h00;
    localparam logic [7:0] ALU_ADD    = 8'h01;
    localparam logic [7:0] ALU_SUB    = 8'h02;
    localparam logic [7:0] ALU_AND    = 8'h03;
    localparam logic [7:0] ALU_OR     = 8'h04;
    localparam logic [7:0] ALU_XOR    = 8'h05;
    localparam logic [7:0] ALU_MULW   = 8'h20;
    localparam logic [7:0] ALU_MULHW  = 8'h21;
    localparam logic [7:0] ALU_MULHWU = 8'h22;
    localparam logic [7:0] ALU_DIVW   = 8'h23;
    localparam logic [7:0] ALU_DIVWU  = 8'h24;
    localparam logic [7:0] ALU_MODW   = 8'h25;
    localparam logic [7:0] ALU_MODWU  = 8'h26;

    // Same classification the ALU uses to decide whether to start its MUL/DIV unit.
    function automatic logic is_mc_op(input logic [7:0] op);
        return op inside {ALU_MULW, ALU_MULHW, ALU_MULHWU, ALU_DIVW,
                          ALU_DIVWU, ALU_MODW, ALU_MODWU};
    endfunction

endpackage

// File: rtl/id_ex_issue.sv
// ID->EX issue register: holds one instruction for the ALU, waits out MUL/DIV,
// and merges single- and multi-cycle results into one valid/ready stream to MEM.
module id_ex_issue
    import id_ex_issue_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_pc,
    input  logic [7:0]  id_alu_op,
    input  logic [31:0] id_src1,
    input  logic [31:0] id_src2,
    input  logic [4:0]  id_rd,
    input  logic        id_rf_we,
    input  logic        flush,
    output logic [7:0]  ex_alu_op,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    input  logic [31:0] alu_c,
    input  logic        mc_done,
    input  logic        mem_ready,
    output logic        ex_out_valid,
    output logic [31:0] ex_out_res,
    output logic [31:0] ex_out_pc,
    output logic [4:0]  ex_out_rd,
    output logic        ex_out_rf_we,
    output logic        mc_timeout
);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_MC_BUSY = 2'd2;
    localparam logic [1:0] S_MC_HOLD = 2'd3;

    localparam int          CW      = $clog2(MC_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MC_TIMEOUT);
    localparam logic [CW-1:0] CNT_TO  = CW'(MC_TIMEOUT - 1);

    logic [1:0]    state, state_nxt;
    logic [31:0]   pc, src1, src2, buffer;
    logic [7:0]    op;
    logic [4:0]    rd;
    logic          rf_we;
    logic [CW-1:0] cnt;
    logic          advance, accept;

    always_comb begin
        id_ready     = 1'b0;
        ex_out_valid = 1'b0;
        advance      = 1'b0;
        case (state)
            S_EMPTY: begin
                id_ready = 1'b1;
                advance  = 1'b1;
            end
            S_ISSUE: begin
                ex_out_valid = 1'b1;
                id_ready     = mem_ready;
                advance      = mem_ready;
            end
            S_MC_BUSY: begin
                ex_out_valid = mc_done;
                id_ready     = mc_done & mem_ready;
                advance      = mc_done & mem_ready;
            end
            default: begin
                ex_out_valid = 1'b1;
                id_ready     = mem_ready;
                advance      = mem_ready;
            end
        endcase
    end

    // A flushed ID instruction is consumed (id_ready still high) but never loaded.
    assign accept    = id_valid & id_ready & ~flush;
    assign state_nxt = accept ? (is_mc_op(id_alu_op) ? S_MC_BUSY : S_ISSUE) : S_EMPTY;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state      <= S_EMPTY;
            pc         <= '0;
            op         <= ALU_NOP;
            src1       <= '0;
            src2       <= '0;
            rd         <= '0;
            rf_we      <= 1'b0;
            buffer     <= '0;
            cnt        <= '0;
            mc_timeout <= 1'b0;
        end else begin
            if (accept) begin
                pc    <= id_pc;
                op    <= id_alu_op;
                src1  <= id_src1;
                src2  <= id_src2;
                rd    <= id_rd;
                rf_we <= id_rf_we;
            end
            if (advance) begin
                state <= state_nxt;
            end else if (state == S_MC_BUSY && mc_done) begin
                state  <= S_MC_HOLD;
                buffer <= alu_c;
            end
            if (advance && state_nxt == S_MC_BUSY)
                cnt <= '0;
            else if (state == S_MC_BUSY && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (state == S_MC_BUSY && cnt == CNT_TO)
                mc_timeout <= 1'b1;
        end
    end

    // NOP outside ISSUE/MC_BUSY keeps the ALU from restarting a finished MUL/DIV.
    assign ex_alu_op    = (state == S_ISSUE || state == S_MC_BUSY) ? op : ALU_NOP;
    assign ex_A         = src1;
    assign ex_B         = src2;
    assign ex_out_res   = (state == S_MC_HOLD) ? buffer :
                          (state == S_EMPTY)   ? 32'd0  : alu_c;
    assign ex_out_pc    = pc;
    assign ex_out_rd    = rd;
    assign ex_out_rf_we = rf_we;

endmodule
